// File: rtl/inst_encoder.sv
// MIPS-style instruction encoder: captures one request, encodes it to a 32-bit
// word and writes it to the next instruction-memory slot over IDLE -> ENC -> WR.
module inst_encoder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_class,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              full,
    output logic [ADDR_W:0]   word_cnt,
    output logic [7:0]        err_cnt
);

    // Handshake: a request is taken on a rising edge where in_valid && in_ready;
    // the requester holds every in_* field stable until that edge.
    typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

    state_t              r_state;
    logic [5:0]          r_class;
    logic [4:0]          r_rs, r_rt, r_rd, r_shamt;
    logic [15:0]         r_imm;
    logic [25:0]         r_target;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [ADDR_W:0]     r_word_cnt;
    logic [7:0]          r_err_cnt;

    logic                w_full;
    logic                w_in_ready;
    logic [5:0]          w_funct;
    logic [5:0]          w_op;
    logic [4:0]          w_rs, w_rt, w_rd, w_shamt;
    logic [31:0]         w_word;

    assign w_full     = (r_word_cnt == (ADDR_W+1)'(DEPTH));
    assign w_in_ready = (r_state == IDLE) && !w_full && !clear;

    assign in_ready   = w_in_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign full       = w_full;
    assign word_cnt   = r_word_cnt;
    assign err_cnt    = r_err_cnt;

    always_comb begin
        w_funct = 6'b000000;
        w_op    = 6'b000000;
        w_rs    = r_rs;
        w_rt    = r_rt;
        w_rd    = r_rd;
        w_shamt = 5'd0;
        w_word  = 32'd0;
        if (r_class <= 6'd16) begin
            case (r_class)
                6'd0:    w_funct = 6'b100000;
                6'd1:    w_funct = 6'b100001;
                6'd2:    w_funct = 6'b100010;
                6'd3:    w_funct = 6'b100011;
                6'd4:    w_funct = 6'b100100;
                6'd5:    w_funct = 6'b100101;
                6'd6:    w_funct = 6'b100110;
                6'd7:    w_funct = 6'b100111;
                6'd8:    w_funct = 6'b101010;
                6'd9:    w_funct = 6'b101011;
                6'd10:   w_funct = 6'b000000;
                6'd11:   w_funct = 6'b000010;
                6'd12:   w_funct = 6'b000011;
                6'd13:   w_funct = 6'b000100;
                6'd14:   w_funct = 6'b000110;
                6'd15:   w_funct = 6'b000111;
                default: w_funct = 6'b001000;
            endcase
            // Only the immediate shifts carry a shift amount, and they have no rs.
            if (r_class >= 6'd10 && r_class <= 6'd12) begin
                w_rs    = 5'd0;
                w_shamt = r_shamt;
            end
            if (r_class == 6'd16) begin
                w_rt = 5'd0;
                w_rd = 5'd0;
            end
            w_word = {6'b000000, w_rs, w_rt, w_rd, w_shamt, w_funct};
        end else if (r_class <= 6'd33) begin
            case (r_class)
                6'd17:   w_op = 6'b001000;
                6'd18:   w_op = 6'b001001;
                6'd19:   w_op = 6'b001100;
                6'd20:   w_op = 6'b001101;
                6'd21:   w_op = 6'b001110;
                6'd22:   w_op = 6'b001111;
                6'd23:   w_op = 6'b100011;
                6'd24:   w_op = 6'b100000;
                6'd25:   w_op = 6'b101011;
                6'd26:   w_op = 6'b101000;
                6'd27:   w_op = 6'b001010;
                6'd28:   w_op = 6'b001011;
                6'd29:   w_op = 6'b000001;
                6'd30:   w_op = 6'b000100;
                6'd31:   w_op = 6'b000101;
                6'd32:   w_op = 6'b000110;
                default: w_op = 6'b000111;
            endcase
            if (r_class == 6'd22)
                w_rs = 5'd0;
            if (r_class == 6'd32 || r_class == 6'd33)
                w_rt = 5'd0;
            w_word = {w_op, w_rs, w_rt, r_imm};
        end else begin
            w_word = {(r_class == 6'd35) ? 6'b000011 : 6'b000010, r_target};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_class    <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_shamt    <= '0;
            r_imm      <= '0;
            r_target   <= '0;
            r_mem_we   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (clear) begin
            r_state    <= IDLE;
            r_mem_we   <= 1'b0;
            r_addr     <= '0;
            r_word_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && w_in_ready) begin
                        if (in_class <= 6'd35) begin
                            r_class  <= in_class;
                            r_rs     <= in_rs;
                            r_rt     <= in_rt;
                            r_rd     <= in_rd;
                            r_shamt  <= in_shamt;
                            r_imm    <= in_imm;
                            r_target <= in_target;
                            r_state  <= ENC;
                        end else if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end
                end
                ENC: begin
                    r_wdata  <= w_word;
                    r_mem_we <= 1'b1;
                    r_state  <= WR;
                end
                WR: begin
                    r_mem_we   <= 1'b0;
                    r_addr     <= r_addr + 1'b1;
                    r_word_cnt <= r_word_cnt + 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule
